// File: rtl/aes_decrypt_iterative.sv
// Iterative AES inverse cipher (one round per clock) with an on-the-fly combinational key schedule.
// Optional feature: define AES_DEC_ABORT_EN to add an abort input that cancels an in-flight block.
module aes_decrypt_iterative #(
  parameter int unsigned N = 128
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
`ifdef AES_DEC_ABORT_EN
  input  logic           abort,
`endif
  input  logic [127:0]   ciphertext,
  input  logic [N-1:0]   key,
  output logic [127:0]   plaintext,
  output logic           valid,
  output logic           busy
);

  localparam int unsigned NK = N / 32;
  localparam int unsigned NR = NK + 6;
  localparam int unsigned NW = 4 * (NR + 1);

  if (N != 128 && N != 192 && N != 256) begin : g_bad_n
    $error("aes_decrypt_iterative: N must be 128, 192 or 256");
  end

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_FINAL = 2'd3;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0).
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return ginv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input int unsigned j);
    logic [7:0] r;
    r = 8'h01;
    for (int unsigned i = 1; i < j; i++) r = xtime(r);
    return r;
  endfunction

  // State byte i = row (i%4), column (i/4); byte 0 sits at bits [127:120].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {
        gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
        gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
        gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
        gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    end
    return o;
  endfunction

  logic [1:0]   r_state, w_state_d;
  logic [127:0] r_ct, w_ct_d;
  logic [N-1:0] r_key, w_key_d;
  logic [127:0] r_st, w_st_d;
  logic [3:0]   r_rnd, w_rnd_d;
  logic [127:0] r_pt, w_pt_d;
  logic         r_valid, w_valid_d;
  logic         r_busy, w_busy_d;

  // Key expansion from the latched key; one named word per generate iteration.
  for (genvar gi = 0; gi < NW; gi++) begin : g_w
    logic [31:0] w_word;
    if (gi < NK) begin : g_init
      assign w_word = r_key[N-1-32*gi -: 32];
    end else begin : g_exp
      logic [31:0] w_tmp;
      if (gi % NK == 0) begin : g_rot
        assign w_tmp = sub_word({g_w[gi-1].w_word[23:0], g_w[gi-1].w_word[31:24]})
                       ^ {rcon(gi / NK), 24'h0};
      end else if (NK > 6 && gi % NK == 4) begin : g_sub
        assign w_tmp = sub_word(g_w[gi-1].w_word);
      end else begin : g_pass
        assign w_tmp = g_w[gi-1].w_word;
      end
      assign w_word = g_w[gi-NK].w_word ^ w_tmp;
    end
  end

  logic [127:0] w_rk [0:NR];
  for (genvar gr = 0; gr <= NR; gr++) begin : g_rk
    assign w_rk[gr] = {g_w[4*gr].w_word, g_w[4*gr+1].w_word,
                       g_w[4*gr+2].w_word, g_w[4*gr+3].w_word};
  end

  logic [3:0]   w_rk_idx;
  logic [127:0] w_rk_sel;
  logic [127:0] w_inv_core;
  logic [127:0] w_round_out;

  always_comb begin
    w_rk_idx = 4'd0;
    case (r_state)
      ST_LOAD:  w_rk_idx = 4'(NR);
      ST_ROUND: w_rk_idx = r_rnd;
      default:  w_rk_idx = 4'd0;
    endcase
  end

  assign w_rk_sel    = w_rk[w_rk_idx];
  // Shared by ROUND and FINAL; FINAL simply skips InvMixColumns.
  assign w_inv_core  = inv_sub_bytes(inv_shift_rows(r_st)) ^ w_rk_sel;
  assign w_round_out = inv_mix_columns(w_inv_core);

  always_comb begin
    w_state_d = r_state;
    w_ct_d    = r_ct;
    w_key_d   = r_key;
    w_st_d    = r_st;
    w_rnd_d   = r_rnd;
    w_pt_d    = r_pt;
    w_valid_d = r_valid;
    w_busy_d  = r_busy;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_ct_d    = ciphertext;
          w_key_d   = key;
          w_valid_d = 1'b0;
          w_busy_d  = 1'b1;
          w_state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_st_d    = r_ct ^ w_rk_sel;
        w_rnd_d   = 4'(NR - 1);
        w_state_d = ST_ROUND;
      end
      ST_ROUND: begin
        w_st_d  = w_round_out;
        w_rnd_d = r_rnd - 4'd1;
        if (r_rnd == 4'd1) w_state_d = ST_FINAL;
      end
      ST_FINAL: begin
        w_pt_d    = w_inv_core;
        w_valid_d = 1'b1;
        w_busy_d  = 1'b0;
        w_state_d = ST_IDLE;
      end
      default: w_state_d = ST_IDLE;
    endcase
`ifdef AES_DEC_ABORT_EN
    // Abort overrides everything, including the FINAL write of plaintext.
    if (abort && r_state != ST_IDLE) begin
      w_state_d = ST_IDLE;
      w_pt_d    = r_pt;
      w_valid_d = 1'b0;
      w_busy_d  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ct    <= '0;
      r_key   <= '0;
      r_st    <= '0;
      r_rnd   <= '0;
      r_pt    <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_ct    <= w_ct_d;
      r_key   <= w_key_d;
      r_st    <= w_st_d;
      r_rnd   <= w_rnd_d;
      r_pt    <= w_pt_d;
      r_valid <= w_valid_d;
      r_busy  <= w_busy_d;
    end
  end

  assign plaintext = r_pt;
  assign valid     = r_valid;
  assign busy      = r_busy;

endmodule

// File: tb/tb_aes_decrypt_iterative.sv
// Bench for aes_decrypt_iterative: three instances (N=128/192/256) checked against FIPS-197 vectors
// and a forward-cipher reference model (random plaintext is encrypted, the DUT must recover it).
module tb_aes_decrypt_iterative;

  logic         clk;
  logic         rst_n;
  logic         start_s [3];
  logic [127:0] ct_s    [3];
  logic [255:0] key_s   [3];
  logic [127:0] pt_s    [3];
  logic         valid_s [3];
  logic         busy_s  [3];
`ifdef AES_DEC_ABORT_EN
  logic         abort;
`endif

  int total;
  int bad;
  logic [7:0] sb [256];

  aes_decrypt_iterative #(.N(128)) u_dut128 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]),
`ifdef AES_DEC_ABORT_EN
    .abort(abort),
`endif
    .ciphertext(ct_s[0]), .key(key_s[0][255:128]),
    .plaintext(pt_s[0]), .valid(valid_s[0]), .busy(busy_s[0]));

  aes_decrypt_iterative #(.N(192)) u_dut192 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]),
`ifdef AES_DEC_ABORT_EN
    .abort(abort),
`endif
    .ciphertext(ct_s[1]), .key(key_s[1][255:64]),
    .plaintext(pt_s[1]), .valid(valid_s[1]), .busy(busy_s[1]));

  aes_decrypt_iterative #(.N(256)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]),
`ifdef AES_DEC_ABORT_EN
    .abort(abort),
`endif
    .ciphertext(ct_s[2]), .key(key_s[2]),
    .plaintext(pt_s[2]), .valid(valid_s[2]), .busy(busy_s[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // GF(2^8) product: carry-less multiply then reduce modulo 0x11B.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, c, s;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
    end
  endtask

  // Forward cipher; key words come from the top nk words of key.
  function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [255:0] key,
                                                 input int nk);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] out;
    int nr;
    nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = gm(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rd < nr) begin
          s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rd + i/4][31-8*(i%4) -: 8];
    end
    out = '0;
    for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
    return out;
  endfunction

  task automatic wait_valid(input int k, input int bound, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < bound) begin
      tick();
      cyc++;
      if (valid_s[k]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One block; with disturb the inputs change after start and start is re-pulsed while busy.
  task automatic run_block(input int k, input logic [127:0] ct, input logic [255:0] key,
                           input logic [127:0] exp_pt, input string tag, input bit disturb);
    logic [127:0] prev;
    int cyc, held, nr;
    bit ok;
    nr   = 10 + 2*k;
    prev = pt_s[k];
    ct_s[k]    = ct;
    key_s[k]   = key;
    start_s[k] = 1'b1;
    tick();
    start_s[k] = 1'b0;
    if (disturb) begin
      ct_s[k]  = rand128();
      key_s[k] = {rand128(), rand128()};
    end
    cyc = 0; held = 0; ok = 1'b0;
    while (cyc < nr + 6) begin
      if (valid_s[k]) begin
        ok = 1'b1;
        break;
      end
      if (busy_s[k] && pt_s[k] === prev) held++;
      start_s[k] = disturb && (cyc == 3);
      tick();
      cyc++;
    end
    start_s[k] = 1'b0;
    check_eq({tag, "_done"}, 128'(ok), 128'd1);
    check_eq({tag, "_latency"}, 128'(cyc), 128'(nr + 1));
    check_eq({tag, "_plaintext"}, pt_s[k], exp_pt);
    check_eq({tag, "_busy_stale"}, 128'(held), 128'(nr + 1));
    check_eq({tag, "_busy_end"}, 128'(busy_s[k]), 128'd0);
  endtask

  task automatic back_to_back(input int k);
    logic [127:0] p1, p2, c1, c2;
    logic [255:0] k1, k2;
    int cy1, cy2, nr;
    bit ok1, ok2;
    nr = 10 + 2*k;
    p1 = rand128(); k1 = {rand128(), rand128()}; c1 = model_encrypt(p1, k1, 4 + 2*k);
    p2 = rand128(); k2 = {rand128(), rand128()}; c2 = model_encrypt(p2, k2, 4 + 2*k);
    ct_s[k] = c1; key_s[k] = k1; start_s[k] = 1'b1;
    tick();
    ct_s[k] = c2; key_s[k] = k2;
    wait_valid(k, nr + 5, cy1, ok1);
    check_eq("b2b_first_done", 128'(ok1), 128'd1);
    check_eq("b2b_first_latency", 128'(cy1), 128'(nr + 1));
    check_eq("b2b_first_pt", pt_s[k], p1);
    tick();
    start_s[k] = 1'b0;
    check_eq("b2b_valid_drop", 128'(valid_s[k]), 128'd0);
    check_eq("b2b_stale_pt", pt_s[k], p1);
    wait_valid(k, nr + 5, cy2, ok2);
    check_eq("b2b_second_done", 128'(ok2), 128'd1);
    check_eq("b2b_spacing", 128'(cy2 + 1), 128'(nr + 2));
    check_eq("b2b_second_pt", pt_s[k], p2);
  endtask

  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] FIPS_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  initial begin
    logic [127:0] fips_ct [3];
    logic [127:0] p;
    logic [255:0] kk;
    total = 0;
    bad   = 0;
    fips_ct[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    fips_ct[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    fips_ct[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0;
      ct_s[k]    = '0;
      key_s[k]   = '0;
    end
`ifdef AES_DEC_ABORT_EN
    abort = 1'b0;
`endif
    rst_n = 1'b0;
    build_sbox();
    repeat (2) tick();
    for (int k = 0; k < 3; k++) begin
      check_eq("reset_pt", pt_s[k], 128'd0);
      check_eq("reset_valid", 128'(valid_s[k]), 128'd0);
      check_eq("reset_busy", 128'(busy_s[k]), 128'd0);
    end
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 3; k++) begin
      run_block(k, fips_ct[k], FIPS_KEY, FIPS_PT, "fips", 1'b0);
      run_block(k, fips_ct[k], FIPS_KEY, FIPS_PT, "fips_disturb", 1'b1);
    end

    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) begin
        p  = rand128();
        kk = {rand128(), rand128()};
        run_block(k, model_encrypt(p, kk, 4 + 2*k), kk, p, "rand", j == 1);
      end
    end

    for (int k = 0; k < 3; k++) back_to_back(k);

    // Asynchronous reset in the middle of a block.
    ct_s[0] = fips_ct[0]; key_s[0] = FIPS_KEY; start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check_eq("midrst_pt", pt_s[k], 128'd0);
      check_eq("midrst_valid", 128'(valid_s[k]), 128'd0);
      check_eq("midrst_busy", 128'(busy_s[k]), 128'd0);
    end
    #2;
    rst_n = 1'b1;
    repeat (14) tick();
    check_eq("midrst_no_resume", 128'(valid_s[0]), 128'd0);
    run_block(0, fips_ct[0], FIPS_KEY, FIPS_PT, "after_rst", 1'b0);

`ifdef AES_DEC_ABORT_EN
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_idle_valid", 128'(valid_s[0]), 128'd1);
    check_eq("abort_idle_pt", pt_s[0], FIPS_PT);
    ct_s[0] = rand128(); start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_busy", 128'(busy_s[0]), 128'd0);
    check_eq("abort_valid", 128'(valid_s[0]), 128'd0);
    check_eq("abort_pt", pt_s[0], FIPS_PT);
    repeat (14) tick();
    check_eq("abort_no_finish", 128'(valid_s[0]), 128'd0);
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    repeat (10) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_final_valid", 128'(valid_s[0]), 128'd0);
    check_eq("abort_final_pt", pt_s[0], FIPS_PT);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
